// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
// Register-read stage sitting between decode and execute.
//   - Drives the register file read addresses straight from decode.
//   - Resolves read-after-write hazards: EX result first, then writeback,
//     then the register file data returned in the same cycle.
//   - Holds decode off (and lets a bubble through) when an instruction needs
//     a load result that is still in EX.
//   - Presents a registered instruction to execute over valid/ready.
//   - Counts load-use stall cycles in a saturating counter.
//
// Optional feature (macro OPFETCH_ZERO_REG_EN):
//   when defined, register 0 reads as constant zero, never matches EX/WB
//   forwarding and never raises a load-use hazard. Undefined: r0 is ordinary.
//
// Ports:
//   clk, rst_n_i                      clock, async active-low reset
//   dec_*_i / dec_ready_o             decode-side instruction handshake
//   ra0_o, ra1_o / rd0_i, rd1_i       register file read port (same cycle)
//   ex_fwd_*_i                        instruction currently in EX
//   wb_*_i                            writeback port
//   flush_i                           squash held instruction, block accept
//   ex_valid_o / ex_ready_i, ex_*_o   registered instruction to execute
//   stall_cnt_o                       saturating load-use stall counter
// -----------------------------------------------------------------------------
module operand_fetch #(
    parameter int SEL_WIDTH = 4,
    parameter int D_WIDTH   = 34,
    parameter int OP_WIDTH  = 6,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n_i,
    input  logic                 dec_valid_i,
    output logic                 dec_ready_o,
    input  logic [OP_WIDTH-1:0]  dec_op_i,
    input  logic [SEL_WIDTH-1:0] dec_rs0_i,
    input  logic [SEL_WIDTH-1:0] dec_rs1_i,
    input  logic                 dec_use_rs0_i,
    input  logic                 dec_use_rs1_i,
    input  logic                 dec_use_imm_i,
    input  logic [D_WIDTH-1:0]   dec_imm_i,
    input  logic [SEL_WIDTH-1:0] dec_rd_i,
    input  logic                 dec_wen_i,
    input  logic                 dec_is_load_i,
    output logic [SEL_WIDTH-1:0] ra0_o,
    output logic [SEL_WIDTH-1:0] ra1_o,
    input  logic [D_WIDTH-1:0]   rd0_i,
    input  logic [D_WIDTH-1:0]   rd1_i,
    input  logic                 ex_fwd_wen_i,
    input  logic                 ex_fwd_is_load_i,
    input  logic [SEL_WIDTH-1:0] ex_fwd_wa_i,
    input  logic [D_WIDTH-1:0]   ex_fwd_wd_i,
    input  logic                 wb_wen_i,
    input  logic [SEL_WIDTH-1:0] wb_wa_i,
    input  logic [D_WIDTH-1:0]   wb_wd_i,
    input  logic                 flush_i,
    output logic                 ex_valid_o,
    input  logic                 ex_ready_i,
    output logic [OP_WIDTH-1:0]  ex_op_o,
    output logic [D_WIDTH-1:0]   ex_a_o,
    output logic [D_WIDTH-1:0]   ex_b_o,
    output logic [SEL_WIDTH-1:0] ex_rd_o,
    output logic                 ex_wen_o,
    output logic                 ex_is_load_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o
);

`ifdef OPFETCH_ZERO_REG_EN
    localparam logic ZERO_REG = 1'b1;
`else
    localparam logic ZERO_REG = 1'b0;
`endif

    // An address takes part in forwarding/hazards unless it is the
    // hard-wired zero register.
    function automatic logic addr_live(input logic [SEL_WIDTH-1:0] addr);
        addr_live = !(ZERO_REG && (addr == {SEL_WIDTH{1'b0}}));
    endfunction

    // Youngest visible value of a source: EX result, then writeback
    // (covers the regfile write landing on this same edge), then regfile.
    function automatic logic [D_WIDTH-1:0] fwd_operand(
        input logic [SEL_WIDTH-1:0] rs,
        input logic [D_WIDTH-1:0]   rf_data,
        input logic                 ex_wen,
        input logic                 ex_is_load,
        input logic [SEL_WIDTH-1:0] ex_wa,
        input logic [D_WIDTH-1:0]   ex_wd,
        input logic                 wb_wen,
        input logic [SEL_WIDTH-1:0] wb_wa,
        input logic [D_WIDTH-1:0]   wb_wd
    );
        logic [D_WIDTH-1:0] val;
        if (!addr_live(rs)) begin
            val = {D_WIDTH{1'b0}};
        end else if (ex_wen && !ex_is_load && (ex_wa == rs)) begin
            val = ex_wd;
        end else if (wb_wen && (wb_wa == rs)) begin
            val = wb_wd;
        end else begin
            val = rf_data;
        end
        fwd_operand = val;
    endfunction

    logic [D_WIDTH-1:0]   opa_s;
    logic [D_WIDTH-1:0]   src1_s;
    logic [D_WIDTH-1:0]   opb_s;
    logic                 dep0_s;
    logic                 dep1_s;
    logic                 hazard_s;
    logic                 dec_ready_s;
    logic                 accept_s;

    logic                 ex_valid_r;
    logic [OP_WIDTH-1:0]  ex_op_r;
    logic [D_WIDTH-1:0]   ex_a_r;
    logic [D_WIDTH-1:0]   ex_b_r;
    logic [SEL_WIDTH-1:0] ex_rd_r;
    logic                 ex_wen_r;
    logic                 ex_is_load_r;
    logic [CNT_WIDTH-1:0] stall_cnt_r;

    // Operand selection with forwarding; operand B may be the immediate.
    always_comb begin
        opa_s  = fwd_operand(dec_rs0_i, rd0_i, ex_fwd_wen_i, ex_fwd_is_load_i,
                             ex_fwd_wa_i, ex_fwd_wd_i, wb_wen_i, wb_wa_i, wb_wd_i);
        src1_s = fwd_operand(dec_rs1_i, rd1_i, ex_fwd_wen_i, ex_fwd_is_load_i,
                             ex_fwd_wa_i, ex_fwd_wd_i, wb_wen_i, wb_wa_i, wb_wd_i);
        if (dec_use_imm_i) begin
            opb_s = dec_imm_i;
        end else begin
            opb_s = src1_s;
        end
    end

    // Load-use detection and the decode-side handshake. Source 1 is only
    // a dependency when it is actually read (not replaced by the immediate).
    always_comb begin
        dep0_s      = dec_use_rs0_i && addr_live(dec_rs0_i) &&
                      (ex_fwd_wa_i == dec_rs0_i);
        dep1_s      = dec_use_rs1_i && !dec_use_imm_i && addr_live(dec_rs1_i) &&
                      (ex_fwd_wa_i == dec_rs1_i);
        hazard_s    = dec_valid_i && ex_fwd_wen_i && ex_fwd_is_load_i &&
                      (dep0_s || dep1_s);
        dec_ready_s = !flush_i && !hazard_s && (!ex_valid_r || ex_ready_i);
        accept_s    = dec_valid_i && dec_ready_s;
    end

    // Output register: flush beats capture beats drain; otherwise hold.
    // Payload is only written on capture, so it is stable under backpressure.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_valid_r   <= 1'b0;
            ex_op_r      <= {OP_WIDTH{1'b0}};
            ex_a_r       <= {D_WIDTH{1'b0}};
            ex_b_r       <= {D_WIDTH{1'b0}};
            ex_rd_r      <= {SEL_WIDTH{1'b0}};
            ex_wen_r     <= 1'b0;
            ex_is_load_r <= 1'b0;
        end else if (flush_i) begin
            ex_valid_r   <= 1'b0;
        end else if (accept_s) begin
            ex_valid_r   <= 1'b1;
            ex_op_r      <= dec_op_i;
            ex_a_r       <= opa_s;
            ex_b_r       <= opb_s;
            ex_rd_r      <= dec_rd_i;
            ex_wen_r     <= dec_wen_i;
            ex_is_load_r <= dec_is_load_i;
        end else if (ex_valid_r && ex_ready_i) begin
            ex_valid_r   <= 1'b0;
        end
    end

    // Saturating count of load-use stall cycles (not counted while flushing).
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (hazard_s && !flush_i && (stall_cnt_r != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign ra0_o        = dec_rs0_i;
    assign ra1_o        = dec_rs1_i;
    assign dec_ready_o  = dec_ready_s;
    assign ex_valid_o   = ex_valid_r;
    assign ex_op_o      = ex_op_r;
    assign ex_a_o       = ex_a_r;
    assign ex_b_o       = ex_b_r;
    assign ex_rd_o      = ex_rd_r;
    assign ex_wen_o     = ex_wen_r;
    assign ex_is_load_o = ex_is_load_r;
    assign stall_cnt_o  = stall_cnt_r;

endmodule

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
// Directed steps from the test plan followed by randomized traffic. Expected
// values come from a behavioural model: each source sees the youngest write
// to its register (regfile < writeback < non-load EX result), a load in EX
// blocks any instruction that needs its destination, and the output slot
// follows flush / accept / drain rules.
// -----------------------------------------------------------------------------
module tb_operand_fetch;
    localparam int SW = 4;
    localparam int DW = 34;
    localparam int OW = 6;
    localparam int CW = 16;
`ifdef OPFETCH_ZERO_REG_EN
    localparam bit TB_ZR = 1'b1;
`else
    localparam bit TB_ZR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic          dec_valid_i, dec_ready_o;
    logic [OW-1:0] dec_op_i;
    logic [SW-1:0] dec_rs0_i, dec_rs1_i, dec_rd_i;
    logic          dec_use_rs0_i, dec_use_rs1_i, dec_use_imm_i;
    logic [DW-1:0] dec_imm_i;
    logic          dec_wen_i, dec_is_load_i;
    logic [SW-1:0] ra0_o, ra1_o;
    logic [DW-1:0] rd0_i, rd1_i;
    logic          ex_fwd_wen_i, ex_fwd_is_load_i;
    logic [SW-1:0] ex_fwd_wa_i;
    logic [DW-1:0] ex_fwd_wd_i;
    logic          wb_wen_i;
    logic [SW-1:0] wb_wa_i;
    logic [DW-1:0] wb_wd_i;
    logic          flush_i;
    logic          ex_valid_o, ex_ready_i;
    logic [OW-1:0] ex_op_o;
    logic [DW-1:0] ex_a_o, ex_b_o;
    logic [SW-1:0] ex_rd_o;
    logic          ex_wen_o, ex_is_load_o;
    logic [CW-1:0] stall_cnt_o;

    operand_fetch dut (
        .clk(clk), .rst_n_i(rst_n_i),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o), .dec_op_i(dec_op_i),
        .dec_rs0_i(dec_rs0_i), .dec_rs1_i(dec_rs1_i),
        .dec_use_rs0_i(dec_use_rs0_i), .dec_use_rs1_i(dec_use_rs1_i),
        .dec_use_imm_i(dec_use_imm_i), .dec_imm_i(dec_imm_i), .dec_rd_i(dec_rd_i),
        .dec_wen_i(dec_wen_i), .dec_is_load_i(dec_is_load_i),
        .ra0_o(ra0_o), .ra1_o(ra1_o), .rd0_i(rd0_i), .rd1_i(rd1_i),
        .ex_fwd_wen_i(ex_fwd_wen_i), .ex_fwd_is_load_i(ex_fwd_is_load_i),
        .ex_fwd_wa_i(ex_fwd_wa_i), .ex_fwd_wd_i(ex_fwd_wd_i),
        .wb_wen_i(wb_wen_i), .wb_wa_i(wb_wa_i), .wb_wd_i(wb_wd_i),
        .flush_i(flush_i), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_op_o(ex_op_o), .ex_a_o(ex_a_o), .ex_b_o(ex_b_o), .ex_rd_o(ex_rd_o),
        .ex_wen_o(ex_wen_o), .ex_is_load_o(ex_is_load_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic          m_valid;
    logic [OW-1:0] m_op;
    logic [DW-1:0] m_a, m_b;
    logic [SW-1:0] m_rd;
    logic          m_wen, m_ld;
    logic [CW-1:0] m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_op = '0; m_a = '0; m_b = '0;
        m_rd = '0; m_wen = 1'b0; m_ld = 1'b0; m_cnt = '0;
    endtask

    task automatic idle_inputs();
        dec_valid_i = 1'b0; dec_op_i = '0; dec_rs0_i = '0; dec_rs1_i = '0;
        dec_use_rs0_i = 1'b0; dec_use_rs1_i = 1'b0; dec_use_imm_i = 1'b0;
        dec_imm_i = '0; dec_rd_i = '0; dec_wen_i = 1'b0; dec_is_load_i = 1'b0;
        rd0_i = '0; rd1_i = '0;
        ex_fwd_wen_i = 1'b0; ex_fwd_is_load_i = 1'b0; ex_fwd_wa_i = '0; ex_fwd_wd_i = '0;
        wb_wen_i = 1'b0; wb_wa_i = '0; wb_wd_i = '0;
        flush_i = 1'b0; ex_ready_i = 1'b1;
    endtask

    function automatic bit is_zero_reg(input logic [SW-1:0] r);
        return TB_ZR && (r == '0);
    endfunction

    // Value of register r as seen now: apply writes oldest to youngest.
    function automatic logic [DW-1:0] visible(input logic [SW-1:0] r, input logic [DW-1:0] rf);
        logic [DW-1:0] v;
        v = rf;
        if (wb_wen_i && wb_wa_i == r) v = wb_wd_i;
        if (ex_fwd_wen_i && !ex_fwd_is_load_i && ex_fwd_wa_i == r) v = ex_fwd_wd_i;
        if (is_zero_reg(r)) v = '0;
        return v;
    endfunction

    // A load in EX whose result this instruction needs.
    function automatic bit load_use();
        bit need0, need1;
        need0 = dec_use_rs0_i && !is_zero_reg(dec_rs0_i) && dec_rs0_i == ex_fwd_wa_i;
        need1 = dec_use_rs1_i && !dec_use_imm_i && !is_zero_reg(dec_rs1_i) &&
                dec_rs1_i == ex_fwd_wa_i;
        return dec_valid_i && ex_fwd_wen_i && ex_fwd_is_load_i && (need0 || need1);
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, 64'(ex_valid_o), 64'(m_valid));
        chk({tag, ".a"}, 64'(ex_a_o), 64'(m_a));
        chk({tag, ".b"}, 64'(ex_b_o), 64'(m_b));
        chk({tag, ".ctl"}, 64'({ex_op_o, ex_rd_o, ex_wen_o, ex_is_load_o}),
            64'({m_op, m_rd, m_wen, m_ld}));
        chk({tag, ".cnt"}, 64'(stall_cnt_o), 64'(m_cnt));
    endtask

    // One cycle: inputs already applied; check combinational side, clock,
    // advance the model, check registered side.
    task automatic step(input string tag);
        bit haz, rdy;
        logic [DW-1:0] a, b;
        #2;
        haz = load_use();
        rdy = !flush_i && !haz && (!m_valid || ex_ready_i);
        chk({tag, ".ready"}, 64'(dec_ready_o), 64'(rdy));
        chk({tag, ".ra"}, 64'({ra0_o, ra1_o}), 64'({dec_rs0_i, dec_rs1_i}));
        a = visible(dec_rs0_i, rd0_i);
        b = dec_use_imm_i ? dec_imm_i : visible(dec_rs1_i, rd1_i);
        @(posedge clk);
        if (flush_i) begin
            m_valid = 1'b0;
        end else if (dec_valid_i && rdy) begin
            m_valid = 1'b1; m_op = dec_op_i; m_a = a; m_b = b;
            m_rd = dec_rd_i; m_wen = dec_wen_i; m_ld = dec_is_load_i;
        end else if (m_valid && ex_ready_i) begin
            m_valid = 1'b0;
        end
        if (haz && !flush_i && m_cnt != '1) m_cnt = m_cnt + 1'b1;
        #1;
        check_outputs(tag);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n_i = 1'b1;
        check_outputs("reset");

        // reset mid-transfer
        dec_valid_i = 1'b1; dec_rs0_i = 4'd3; dec_use_rs0_i = 1'b1;
        rd0_i = 34'h1234; dec_op_i = 6'h2A; ex_ready_i = 1'b0;
        step("rmt_cap");
        chk("rmt_a_before", 64'(ex_a_o), 64'h1234);
        rst_n_i = 1'b0;
        #1;
        chk("rmt_valid_async", 64'(ex_valid_o), 64'h0);
        chk("rmt_a_async", 64'(ex_a_o), 64'h0);
        model_reset();
        check_outputs("rmt");
        rst_n_i = 1'b1;

        // plain read
        idle_inputs();
        dec_valid_i = 1'b1; dec_rs0_i = 4'd3; dec_rs1_i = 4'd5;
        dec_use_rs0_i = 1'b1; dec_use_rs1_i = 1'b1;
        rd0_i = 34'h11; rd1_i = 34'h22; dec_rd_i = 4'd9; dec_wen_i = 1'b1;
        step("plain");
        chk("plain_a", 64'(ex_a_o), 64'h11);
        chk("plain_b", 64'(ex_b_o), 64'h22);
        chk("plain_v", 64'(ex_valid_o), 64'h1);

        // forwarding priority: EX over WB, then WB alone
        dec_rs0_i = 4'd7; rd0_i = 34'h5;
        ex_fwd_wen_i = 1'b1; ex_fwd_wa_i = 4'd7; ex_fwd_wd_i = 34'hAA;
        wb_wen_i = 1'b1; wb_wa_i = 4'd7; wb_wd_i = 34'hBB;
        step("fwd_ex");
        chk("fwd_ex_a", 64'(ex_a_o), 64'hAA);
        ex_fwd_wen_i = 1'b0;
        step("fwd_wb");
        chk("fwd_wb_a", 64'(ex_a_o), 64'hBB);

        // load-use on rs1, then released
        idle_inputs();
        dec_valid_i = 1'b1; dec_rs1_i = 4'd4; dec_use_rs1_i = 1'b1; rd1_i = 34'h44;
        ex_fwd_wen_i = 1'b1; ex_fwd_is_load_i = 1'b1; ex_fwd_wa_i = 4'd4;
        #1;
        chk("lu_ready", 64'(dec_ready_o), 64'h0);
        step("lu_stall");
        chk("lu_bubble", 64'(ex_valid_o), 64'h0);
        chk("lu_cnt", 64'(stall_cnt_o), 64'h1);
        ex_fwd_wen_i = 1'b0; ex_fwd_is_load_i = 1'b0;
        step("lu_go");
        chk("lu_go_v", 64'(ex_valid_o), 64'h1);
        chk("lu_go_b", 64'(ex_b_o), 64'h44);

        // backpressure for 3 cycles, then flush
        ex_ready_i = 1'b0; rd1_i = 34'h77; dec_op_i = 6'h11;
        for (int i = 0; i < 3; i++) begin
            step("bp");
            chk("bp_b_const", 64'(ex_b_o), 64'h44);
            chk("bp_ready", 64'(dec_ready_o), 64'h0);
        end
        flush_i = 1'b1;
        step("flush");
        chk("flush_v", 64'(ex_valid_o), 64'h0);
        chk("flush_b", 64'(ex_b_o), 64'h44);

        // register 0 forwarding
        idle_inputs();
        dec_valid_i = 1'b1; dec_rs0_i = 4'd0; dec_use_rs0_i = 1'b1; rd0_i = 34'h55;
        ex_fwd_wen_i = 1'b1; ex_fwd_wa_i = 4'd0; ex_fwd_wd_i = 34'h99;
        step("zr");
        chk("zr_a", 64'(ex_a_o), TB_ZR ? 64'h0 : 64'h99);

        // randomized traffic with address collisions favoured
        for (int i = 0; i < 600; i++) begin
            dec_valid_i      = ($urandom_range(0, 3) != 0);
            dec_op_i         = OW'($urandom);
            dec_rs0_i        = SW'($urandom_range(0, 3));
            dec_rs1_i        = SW'($urandom_range(0, 3));
            dec_use_rs0_i    = 1'($urandom);
            dec_use_rs1_i    = 1'($urandom);
            dec_use_imm_i    = ($urandom_range(0, 3) == 0);
            dec_imm_i        = DW'({$urandom, $urandom});
            dec_rd_i         = SW'($urandom);
            dec_wen_i        = 1'($urandom);
            dec_is_load_i    = 1'($urandom);
            rd0_i            = DW'({$urandom, $urandom});
            rd1_i            = DW'({$urandom, $urandom});
            ex_fwd_wen_i     = 1'($urandom);
            ex_fwd_is_load_i = ($urandom_range(0, 2) == 0);
            ex_fwd_wa_i      = SW'($urandom_range(0, 3));
            ex_fwd_wd_i      = DW'({$urandom, $urandom});
            wb_wen_i         = 1'($urandom);
            wb_wa_i          = SW'($urandom_range(0, 3));
            wb_wd_i          = DW'({$urandom, $urandom});
            flush_i          = ($urandom_range(0, 15) == 0);
            ex_ready_i       = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        // stall counter saturation under a long load-use stall
        idle_inputs();
        dec_valid_i = 1'b1; dec_rs0_i = 4'd2; dec_use_rs0_i = 1'b1;
        ex_fwd_wen_i = 1'b1; ex_fwd_is_load_i = 1'b1; ex_fwd_wa_i = 4'd2;
        repeat (65540) @(posedge clk);
        #1;
        m_valid = 1'b0;
        m_cnt = '1;
        check_outputs("sat");
        chk("sat_cnt", 64'(stall_cnt_o), 64'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Register-read stage between decode and execute.
- Drives the register file's two read addresses and captures the returned operands.
- Resolves read-after-write hazards by forwarding from EX and writeback, and stalls decode on a load-use dependency.
- Presents registered operands to execute over a valid/ready handshake.

Parameters:
SEL_WIDTH, 4, bits of a register address
D_WIDTH, 34, operand/data width
OP_WIDTH, 6, opcode field passed through to execute
CNT_WIDTH, 16, width of stall performance counter

Ports:
clk  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
dec_valid_i  in  1  decode presents an instruction
dec_ready_o  out  1  stage accepts instruction this cycle
dec_op_i  in  OP_WIDTH  opcode
dec_rs0_i  in  SEL_WIDTH  source 0 address
dec_rs1_i  in  SEL_WIDTH  source 1 address
dec_use_rs0_i  in  1  source 0 is read
dec_use_rs1_i  in  1  source 1 is read
dec_use_imm_i  in  1  operand B is immediate instead of rs1 data
dec_imm_i  in  D_WIDTH  immediate, already extended
dec_rd_i  in  SEL_WIDTH  destination
dec_wen_i  in  1  instruction writes rd
dec_is_load_i  in  1  instruction is a load
ra0_o  out  SEL_WIDTH  to regfile read port 0 (= dec_rs0_i, combinational)
ra1_o  out  SEL_WIDTH  to regfile read port 1 (= dec_rs1_i, combinational)
rd0_i  in  D_WIDTH  regfile read data 0, same cycle
rd1_i  in  D_WIDTH  regfile read data 1, same cycle
ex_fwd_wen_i  in  1  instruction in EX writes a register
ex_fwd_is_load_i  in  1  instruction in EX is a load, result not yet available
ex_fwd_wa_i  in  SEL_WIDTH  EX destination
ex_fwd_wd_i  in  D_WIDTH  EX result
wb_wen_i  in  1  writeback writing regfile this cycle
wb_wa_i  in  SEL_WIDTH  writeback address
wb_wd_i  in  D_WIDTH  writeback data
flush_i  in  1  squash held instruction and block accept
ex_valid_o  out  1  output register holds valid instruction
ex_ready_i  in  1  execute consumes output
ex_op_o  out  OP_WIDTH  registered opcode
ex_a_o  out  D_WIDTH  registered operand A
ex_b_o  out  D_WIDTH  registered operand B
ex_rd_o  out  SEL_WIDTH  registered destination
ex_wen_o  out  1  registered write enable
ex_is_load_o  out  1  registered load flag
stall_cnt_o  out  CNT_WIDTH  count of load-use stall cycles, saturating

Behaviour:
- Reset (async, rst_n_i low): ex_valid_o=0; ex_op_o, ex_a_o, ex_b_o, ex_rd_o, ex_wen_o, ex_is_load_o all 0; stall_cnt_o=0. Combinational outputs (dec_ready_o, ra*_o) follow their inputs during reset, but nothing is captured.
- Operand select per source, priority high to low:
  - (1) EX match: ex_fwd_wen_i & !ex_fwd_is_load_i & ex_fwd_wa_i==rs gives ex_fwd_wd_i.
  - (2) WB match: wb_wen_i & wb_wa_i==rs gives wb_wd_i. Covers the regfile write landing on the same edge.
  - (3) Otherwise rdN_i.
- ex_b_o = dec_imm_i when dec_use_imm_i, else forwarded source 1.
- hazard = dec_valid_i & ex_fwd_wen_i & ex_fwd_is_load_i & ((dec_use_rs0_i & ex_fwd_wa_i==dec_rs0_i) | (dec_use_rs1_i & !dec_use_imm_i & ex_fwd_wa_i==dec_rs1_i)).
- dec_ready_o = !flush_i & !hazard & (!ex_valid_o | ex_ready_i).
- Edge update, first applicable rule wins:
  - flush_i: ex_valid_o<=0.
  - dec_valid_i & dec_ready_o: capture all fields, ex_valid_o<=1. Latency is 1 cycle.
  - ex_valid_o & ex_ready_i: ex_valid_o<=0. A bubble is inserted when hazard holds.
  - Otherwise: hold all outputs stable. Payload must not change while ex_valid_o & !ex_ready_i.
- stall_cnt_o increments on each cycle with hazard & !flush_i and saturates at all-ones.
- Back-to-back: full throughput with ex_ready_i held at 1 and no hazards.
- Source not used: no forwarding or hazard is evaluated for it, and its data is don't-care (captured as selected anyway).

Optional Feature:
- Macro: OPFETCH_ZERO_REG_EN.
- When defined:
  - Register address 0 reads as constant 0.
  - Address 0 never matches EX/WB forwarding and never raises hazard.
- When undefined: register 0 is an ordinary register.

Test Plan:
- Reset mid-transfer: ex_valid_o=1 with ex_a_o=0x1234, assert rst_n_i=0 -> ex_valid_o and ex_a_o are 0 immediately, without waiting for a clock edge.
- Plain read: rs0=3, rs1=5, rd0_i=0x11, rd1_i=0x22, no forwards -> next cycle ex_a_o=0x11, ex_b_o=0x22, ex_valid_o=1.
- Forward priority: rs0=7, EX writes r7=0xAA and WB writes r7=0xBB -> ex_a_o=0xAA. With EX idle -> ex_a_o=0xBB.
- Load-use: EX load to r4, decode uses rs1=4 with imm=0 -> dec_ready_o=0, bubble (ex_valid_o=0), stall_cnt_o 0->1. Next cycle EX clear -> instruction accepted.
- Backpressure and flush: ex_ready_i=0 for 3 cycles -> payload constant, dec_ready_o=0. Then flush_i=1 -> ex_valid_o=0 next edge and no instruction captured.
- OPFETCH_ZERO_REG_EN: rs0=0, rd0_i=0x55, EX writes r0=0x99 -> ex_a_o=0. With the macro off -> ex_a_o=0x99.
